// File: rtl/cnt_chk_pkg.sv
// cnt_chk_pkg: shared state encoding, default parameters and saturation helper for count_seq_checker
package cnt_chk_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACQ  = 2'd1,
      LOCK = 2'd2
   } state_t;

   localparam int unsigned DEF_N        = 4;
   localparam int unsigned DEF_LOCK_CNT = 3;
   localparam int unsigned DEF_STAT_W   = 16;

   function automatic logic [31:0] sat_max(input int unsigned w);
      return (w >= 32) ? 32'hFFFF_FFFF : (32'd1 << w) - 32'd1;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up-counter that sticks at its maximum value until reset
module sat_counter
   import cnt_chk_pkg::*;
#(
   parameter int unsigned W = DEF_STAT_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] q
);

   localparam logic [W-1:0] MAX = W'(sat_max(W));

   // count up on inc, never wrapping past MAX
   always_ff @(posedge clk or posedge rst)
      if (rst) q <= '0;
      else if (inc && q != MAX) q <= q + 1'b1;

endmodule

// File: rtl/count_seq_checker.sv
// count_seq_checker: locks onto an N-bit up-count and flags breaks; wrap stats with CNT_CHK_WRAP_STAT_EN
module count_seq_checker
   import cnt_chk_pkg::*;
#(
   parameter int unsigned N        = DEF_N,
   parameter int unsigned LOCK_CNT = DEF_LOCK_CNT,
   parameter int unsigned STAT_W   = DEF_STAT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [N-1:0]      cnt_in,
   output logic              locked,
   output logic              err_pulse,
   output logic [STAT_W-1:0] err_cnt
`ifdef CNT_CHK_WRAP_STAT_EN
   ,
   output logic [STAT_W-1:0] wrap_cnt
`endif
);

   localparam int unsigned RW = $clog2(LOCK_CNT + 1);

   state_t          state, state_nxt;
   logic [N-1:0]    prev, exp_val;
   logic [RW-1:0]   run, run_inc, run_nxt;
   logic            match, err_inc;

   // next-state, run length and break detection for one qualified sample
   always_comb begin
      exp_val   = prev + 1'b1;
      match     = cnt_in == exp_val;
      run_inc   = run + 1'b1;
      state_nxt = (state == IDLE) ? ACQ :
                  (state == ACQ)  ? ((match && run_inc == RW'(LOCK_CNT)) ? LOCK : ACQ) :
                  (match ? LOCK : ACQ);
      run_nxt   = (state == ACQ && match) ? run_inc :
                  (state == LOCK && match) ? run : '0;
      err_inc   = en && state == LOCK && !match;
   end

   // FSM, sample history and registered outputs; everything holds while en is low
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state     <= IDLE;
         prev      <= '0;
         run       <= '0;
         locked    <= 1'b0;
         err_pulse <= 1'b0;
      end else begin
         err_pulse <= err_inc;
         if (en) begin
            state  <= state_nxt;
            prev   <= cnt_in;
            run    <= run_nxt;
            locked <= state_nxt == LOCK;
         end
      end

   sat_counter #(.W(STAT_W)) u_err (
      .clk (clk),
      .rst (rst),
      .inc (err_inc),
      .q   (err_cnt)
   );

`ifdef CNT_CHK_WRAP_STAT_EN
   logic wrap_inc;
   assign wrap_inc = en && state == LOCK && match && prev == '1;

   sat_counter #(.W(STAT_W)) u_wrap (
      .clk (clk),
      .rst (rst),
      .inc (wrap_inc),
      .q   (wrap_cnt)
   );
`endif

endmodule

// File: tb/tb_count_seq_checker.sv
// tb_count_seq_checker: directed scoreboard bench for count_seq_checker (N=4, LOCK_CNT=3)
module tb_count_seq_checker;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic [3:0]  cnt_in = '0;
   logic        locked, err_pulse, locked_s, err_pulse_s;
   logic [15:0] err_cnt;
   logic [1:0]  err_cnt_s;
`ifdef CNT_CHK_WRAP_STAT_EN
   logic [15:0] wrap_cnt;
   logic [1:0]  wrap_cnt_s;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct {
      logic        l;
      logic        p;
      logic [15:0] e;
      logic [1:0]  s;
      logic [15:0] w;
   } exp_t;

   exp_t sb[$];

   // reference model state
   int m_state = 0;
   int m_prev  = 0;
   int m_run   = 0;
   int m_err   = 0;
   int m_errs  = 0;
   int m_wrap  = 0;
   int m_pulse = 0;

   always #5 clk = ~clk;

   count_seq_checker #(.N(4), .LOCK_CNT(3), .STAT_W(16)) dut (
      .clk(clk), .rst(rst), .en(en), .cnt_in(cnt_in),
      .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt)
`ifdef CNT_CHK_WRAP_STAT_EN
      , .wrap_cnt(wrap_cnt)
`endif
   );

   count_seq_checker #(.N(4), .LOCK_CNT(3), .STAT_W(2)) dut_s (
      .clk(clk), .rst(rst), .en(en), .cnt_in(cnt_in),
      .locked(locked_s), .err_pulse(err_pulse_s), .err_cnt(err_cnt_s)
`ifdef CNT_CHK_WRAP_STAT_EN
      , .wrap_cnt(wrap_cnt_s)
`endif
   );

   task automatic chk(input string tag, input int obs, input int expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_prev = 0; m_run = 0; m_err = 0; m_errs = 0; m_wrap = 0; m_pulse = 0;
   endtask

   task automatic model_step(input int v, input bit e);
      int ex;
      m_pulse = 0;
      if (e) begin
         ex = (m_prev + 1) % 16;
         if (m_state == 0) begin
            m_run = 0;
            m_state = 1;
         end else if (m_state == 1) begin
            if (v == ex) begin
               m_run++;
               if (m_run == 3) m_state = 2;
            end else m_run = 0;
         end else if (v == ex) begin
            if (m_prev == 15 && m_wrap < 65535) m_wrap++;
         end else begin
            m_pulse = 1;
            if (m_err < 65535) m_err++;
            if (m_errs < 3) m_errs++;
            m_run = 0;
            m_state = 1;
         end
         m_prev = v;
      end
   endtask

   function automatic exp_t model_out();
      exp_t x;
      x.l = (m_state == 2);
      x.p = m_pulse[0];
      x.e = 16'(m_err);
      x.s = 2'(m_errs);
      x.w = 16'(m_wrap);
      return x;
   endfunction

   task automatic check_out(input string tag, input exp_t x);
      chk({tag, ".locked"}, int'(locked), int'(x.l));
      chk({tag, ".err_pulse"}, int'(err_pulse), int'(x.p));
      chk({tag, ".err_cnt"}, int'(err_cnt), int'(x.e));
      chk({tag, ".err_cnt_sat"}, int'(err_cnt_s), int'(x.s));
      chk({tag, ".err_pulse_sat"}, int'(err_pulse_s), int'(x.p));
`ifdef CNT_CHK_WRAP_STAT_EN
      chk({tag, ".wrap_cnt"}, int'(wrap_cnt), int'(x.w));
`endif
   endtask

   task automatic step(input string tag, input int v, input bit e);
      exp_t x;
      @(negedge clk);
      en = e;
      cnt_in = 4'(v);
      model_step(v, e);
      sb.push_back(model_out());
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         chk({tag, ".scoreboard_empty"}, 0, 1);
      end else begin
         x = sb.pop_front();
         check_out(tag, x);
      end
   endtask

   initial begin
      exp_t x;
      repeat (3) @(posedge clk);
      #1;
      model_reset();
      check_out("reset", model_out());
      @(negedge clk);
      rst = 1'b0;

      // lock acquisition
      for (int i = 0; i <= 3; i++) step($sformatf("lock%0d", i), i, 1'b1);
      // break and relock
      for (int v = 5; v <= 8; v++) step($sformatf("brk%0d", v), v, 1'b1);
      // run up through the wrap
      for (int v = 9; v <= 17; v++) step($sformatf("wrap%0d", v % 16), v % 16, 1'b1);
      for (int v = 2; v <= 6; v++) step($sformatf("pre_gap%0d", v), v, 1'b1);
      // en gap: outputs hold, value 9 ignored
      for (int i = 0; i < 10; i++) step($sformatf("gap%0d", i), 9, 1'b0);
      step("after_gap", 7, 1'b1);

      // five break/relock cycles to saturate the narrow counter
      for (int c = 0; c < 5; c++) begin
         step($sformatf("sat_brk%0d", c), (m_prev + 2) % 16, 1'b1);
         for (int k = 0; k < 3; k++) step($sformatf("sat_rel%0d_%0d", c, k), (m_prev + 1) % 16, 1'b1);
      end
      // back-to-back breaks: only the first pulses
      step("b2b0", (m_prev + 5) % 16, 1'b1);
      step("b2b1", (m_prev + 5) % 16, 1'b1);
      for (int k = 0; k < 3; k++) step($sformatf("b2b_rel%0d", k), (m_prev + 1) % 16, 1'b1);

      // asynchronous reset between edges
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      x = model_out();
      check_out("async_rst", x);
      @(negedge clk);
      rst = 1'b0;
      for (int v = 3; v <= 6; v++) step($sformatf("relock%0d", v), v, 1'b1);

      // reset high at an edge wins over a sample
      @(negedge clk);
      rst = 1'b1;
      en = 1'b1;
      cnt_in = 4'd7;
      @(posedge clk);
      #1;
      model_reset();
      check_out("rst_edge", model_out());
      @(negedge clk);
      rst = 1'b0;
      en = 1'b0;

      chk("scoreboard_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
